// File: rtl/gnr_pkg.sv
// Shared definitions for the gene-regulatory-network cycle detector:
// sequencer state encoding and default datapath widths.
package gnr_pkg;

    localparam int GNR_NUM_NODES = 8;
    localparam int GNR_CNT_WIDTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_ISSUE_A = 3'd2,
        ST_ISSUE_B = 3'd3,
        ST_CHECK   = 3'd4,
        ST_ISSUE_P = 3'd5,
        ST_CHECK_P = 3'd6,
        ST_FIN     = 3'd7
    } gnr_state_e;

endpackage

// File: rtl/gnr_vec_cmp.sv
// Register-free equality comparator over a network state vector.
module gnr_vec_cmp #(
    parameter int NUM_NODES = 8
) (
    input  logic [NUM_NODES-1:0] a,
    input  logic [NUM_NODES-1:0] b,
    output logic                 eq
);

    assign eq = (a == b);

endmodule

// File: rtl/gnr_cycle_detector.sv
// Floyd tortoise/hare sequencer for the Boolean network node blocks:
// finds the meeting step, then the attractor period, with a step limit.
module gnr_cycle_detector
    import gnr_pkg::*;
#(
    parameter int NUM_NODES = GNR_NUM_NODES,
    parameter int CNT_WIDTH = GNR_CNT_WIDTH,
    parameter int MAX_STEPS = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NUM_NODES-1:0] init_vec,
    input  logic [NUM_NODES-1:0] s0_vec,
    input  logic [NUM_NODES-1:0] s1_vec,
    output logic                 reset_nos,
    output logic [NUM_NODES-1:0] init_state,
    output logic                 start_s0,
    output logic                 start_s1,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout,
    output logic [CNT_WIDTH-1:0] meet_step,
    output logic [CNT_WIDTH-1:0] period
);

    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_STEPS);

    gnr_state_e           state_r;
    gnr_state_e           state_nx_s;
    logic [CNT_WIDTH-1:0] m_r;
    logic [CNT_WIDTH-1:0] p_r;
    logic                 vec_eq_s;

    gnr_vec_cmp #(
        .NUM_NODES (NUM_NODES)
    ) u_cmp (
        .a  (s0_vec),
        .b  (s1_vec),
        .eq (vec_eq_s)
    );

    // Next-state selection for the meeting and period phases
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nx_s = ST_LOAD;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_LOAD:    state_nx_s = ST_ISSUE_A;
            ST_ISSUE_A: state_nx_s = ST_ISSUE_B;
            ST_ISSUE_B: state_nx_s = ST_CHECK;
            ST_CHECK: begin
                if (vec_eq_s) begin
                    state_nx_s = ST_ISSUE_P;
                end else if (m_r == MAX_CNT) begin
                    state_nx_s = ST_FIN;
                end else begin
                    state_nx_s = ST_ISSUE_A;
                end
            end
            ST_ISSUE_P: state_nx_s = ST_CHECK_P;
            ST_CHECK_P: begin
                if (vec_eq_s || (p_r == MAX_CNT)) begin
                    state_nx_s = ST_FIN;
                end else begin
                    state_nx_s = ST_ISSUE_P;
                end
            end
            ST_FIN:  state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State register and strobes decoded from the state being entered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            reset_nos <= 1'b0;
            start_s0  <= 1'b0;
            start_s1  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            reset_nos <= (state_nx_s == ST_LOAD);
            start_s0  <= (state_nx_s == ST_ISSUE_A) || (state_nx_s == ST_ISSUE_B);
            start_s1  <= (state_nx_s == ST_ISSUE_A) || (state_nx_s == ST_ISSUE_B) ||
                         (state_nx_s == ST_ISSUE_P);
            busy      <= (state_nx_s != ST_IDLE);
            done      <= (state_nx_s == ST_FIN);
        end
    end

    // Step counters and result registers; results hold until the next accepted start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_state <= {NUM_NODES{1'b0}};
            m_r        <= {CNT_WIDTH{1'b0}};
            p_r        <= {CNT_WIDTH{1'b0}};
            timeout    <= 1'b0;
            meet_step  <= {CNT_WIDTH{1'b0}};
            period     <= {CNT_WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        init_state <= init_vec;
                        m_r        <= {CNT_WIDTH{1'b0}};
                        p_r        <= {CNT_WIDTH{1'b0}};
                        timeout    <= 1'b0;
                        meet_step  <= {CNT_WIDTH{1'b0}};
                        period     <= {CNT_WIDTH{1'b0}};
                    end
                end
                ST_ISSUE_B: m_r <= m_r + CNT_WIDTH'(1);
                ST_CHECK: begin
                    if (vec_eq_s) begin
                        meet_step <= m_r;
                        p_r       <= {CNT_WIDTH{1'b0}};
                    end else if (m_r == MAX_CNT) begin
                        timeout <= 1'b1;
                    end
                end
                ST_ISSUE_P: p_r <= p_r + CNT_WIDTH'(1);
                ST_CHECK_P: begin
                    if (vec_eq_s) begin
                        period <= p_r;
                    end else if (p_r == MAX_CNT) begin
                        timeout <= 1'b1;
                    end
                end
                default: begin
                    m_r <= m_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gnr_cycle_detector.sv
// Bench for gnr_cycle_detector: 4-node network model with pass semantics,
// directed table of known networks, random networks against a Floyd model.
module tb_gnr_cycle_detector;

    localparam int NN   = 4;
    localparam int CW   = 16;
    localparam int MAXS = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [NN-1:0] init_vec;
    logic [NN-1:0] s0_vec, s1_vec;
    logic          reset_nos, start_s0, start_s1, busy, done, timeout;
    logic [NN-1:0] init_state;
    logic [CW-1:0] meet_step, period;

    int vectors = 0;
    int miscompares = 0;

    int            cur_kind;
    logic [NN-1:0] rand_net [16];
    logic          pass_r;

    gnr_cycle_detector #(.NUM_NODES(NN), .CNT_WIDTH(CW), .MAX_STEPS(MAXS)) dut (
        .clk(clk), .rst(rst), .start(start), .init_vec(init_vec),
        .s0_vec(s0_vec), .s1_vec(s1_vec), .reset_nos(reset_nos),
        .init_state(init_state), .start_s0(start_s0), .start_s1(start_s1),
        .busy(busy), .done(done), .timeout(timeout),
        .meet_step(meet_step), .period(period)
    );

    always #5 clk = ~clk;

    function automatic logic [NN-1:0] net_f(input logic [NN-1:0] s);
        case (cur_kind)
            0: net_f = s;
            1: net_f = {s[2:0], s[3]};
            2: net_f = s + 4'd1;
            3: net_f = (s < 4'd4) ? s + 4'd1 : ((s == 4'd4) ? 4'd2 : 4'd0);
            default: net_f = rand_net[s];
        endcase
    endfunction

    // Node blocks: load on reset_nos, tortoise steps every second start_s0
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_vec <= '0;
            s1_vec <= '0;
            pass_r <= 1'b0;
        end else if (reset_nos) begin
            s0_vec <= init_state;
            s1_vec <= init_state;
            pass_r <= 1'b1;
        end else begin
            if (start_s0) begin
                if (pass_r) s0_vec <= net_f(s0_vec);
                pass_r <= ~pass_r;
            end
            if (start_s1) s1_vec <= net_f(s1_vec);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Abstract Floyd run: tortoise one step, hare two, then hare alone round the cycle
    task automatic ref_model(input logic [NN-1:0] init, output logic [CW-1:0] em,
                             output logic [CW-1:0] ep, output logic eto, output int elat);
        logic [NN-1:0] t, h;
        int m, p;
        bit met;
        t = init; h = init; em = '0; ep = '0; eto = 1'b0; met = 0; m = 0; p = 0;
        for (int i = 1; i <= MAXS && !met; i++) begin
            t = net_f(t);
            h = net_f(net_f(h));
            m = i;
            if (t == h) met = 1;
        end
        if (!met) begin
            eto = 1'b1;
            elat = 1 + 3 * m + 1;
        end else begin
            em = CW'(m);
            met = 0;
            for (int i = 1; i <= MAXS && !met; i++) begin
                h = net_f(h);
                p = i;
                if (h == t) met = 1;
            end
            if (met) ep = CW'(p);
            else eto = 1'b1;
            elat = 1 + 3 * m + 2 * p + 1;
        end
    endtask

    task automatic chk_strobes();
        chk("reset_nos_with_step", 32'(reset_nos & (start_s0 | start_s1)), 32'd0);
        chk("s0_without_s1", 32'(start_s0 & ~start_s1), 32'd0);
    endtask

    task automatic run(input string nm, input logic [NN-1:0] init, input logic [CW-1:0] em,
                       input logic [CW-1:0] ep, input logic eto, input int elat,
                       input int extra_at, input bit start_at_done);
        int  lat;
        bit  seen;
        lat = 0; seen = 0;
        @(negedge clk);
        init_vec = init;
        start = 1'b1;
        for (int c = 1; c <= 300 && !seen; c++) begin
            @(negedge clk);
            start    = (c == extra_at);
            init_vec = (c == extra_at) ? ~init : init;
            chk_strobes();
            chk({nm, "_busy"}, 32'(busy), 32'd1);
            if (done) begin
                seen = 1;
                lat  = c;
            end
        end
        chk({nm, "_latency"}, 32'(lat), 32'(elat));
        chk({nm, "_timeout"}, 32'(timeout), 32'(eto));
        chk({nm, "_meet_step"}, 32'(meet_step), 32'(em));
        chk({nm, "_period"}, 32'(period), 32'(ep));
        start = start_at_done;
        @(negedge clk);
        start = 1'b0;
        chk({nm, "_done_pulse"}, 32'(done), 32'd0);
        chk({nm, "_busy_after"}, 32'(busy), 32'd0);
        @(negedge clk);
        chk({nm, "_idle_after"}, 32'(busy), 32'd0);
        chk({nm, "_meet_hold"}, 32'(meet_step), 32'(em));
    endtask

    typedef struct {
        int            kind;
        logic [NN-1:0] init;
        logic [CW-1:0] meet;
        logic [CW-1:0] per;
        logic          to;
        int            lat;
        int            extra_at;
        bit            start_at_done;
    } vec_t;

    vec_t tab [4];

    initial begin
        logic [CW-1:0] em, ep;
        logic          eto;
        int            elat;
        bit            hit;

        tab[0] = '{0, 4'b1010, 16'd1, 16'd1, 1'b0, 7,  0, 1'b1};
        tab[1] = '{1, 4'b0001, 16'd4, 16'd4, 1'b0, 22, 3, 1'b0};
        tab[2] = '{2, 4'b0000, 16'd0, 16'd0, 1'b1, 32, 0, 1'b0};
        tab[3] = '{3, 4'b0000, 16'd3, 16'd3, 1'b0, 17, 0, 1'b0};

        cur_kind = 0;
        rst = 1'b1; start = 1'b0; init_vec = '0;
        repeat (3) @(negedge clk);
        chk("rst_outputs", 32'({reset_nos, start_s0, start_s1, busy, done, timeout,
                               meet_step, period, init_state}), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            cur_kind = tab[i].kind;
            run($sformatf("tab%0d", i), tab[i].init, tab[i].meet, tab[i].per, tab[i].to,
                tab[i].lat, tab[i].extra_at, tab[i].start_at_done);
        end

        // Abort a rotate run in the period phase with an async reset
        cur_kind = 1;
        @(negedge clk);
        init_vec = 4'b0001;
        start = 1'b1;
        hit = 0;
        for (int c = 1; c <= 100 && !hit; c++) begin
            @(negedge clk);
            start = (c == 2);
            if (start_s1 && !start_s0 && busy) hit = 1;
        end
        chk("reach_issue_p", 32'(hit), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrun_rst_outputs", 32'({reset_nos, start_s0, start_s1, busy, done, timeout,
                                      meet_step, period, init_state}), 32'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cur_kind = 0;
        run("after_rst", 4'b0110, 16'd1, 16'd1, 1'b0, 7, 0, 1'b0);

        for (int r = 0; r < 20; r++) begin
            cur_kind = 4;
            for (int k = 0; k < 16; k++) rand_net[k] = 4'($urandom_range(0, 15));
            init_vec = 4'($urandom_range(0, 15));
            ref_model(init_vec, em, ep, eto, elat);
            run($sformatf("rand%0d", r), init_vec, em, ep, eto, elat, 0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
